// File: rtl/uart_rx_if.sv
// Host-side handshake bundle of the configurable UART receiver: held word,
// valid/ready pair and per-frame status flags.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_data, rx_valid, parity_err, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, frame_err, overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1..2 stop bits).
// Define UART_RX_MAJORITY_EN for 3-sample majority voting on every bit.
module uart_rx_cfg #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      rx,
    output logic      busy,
    uart_rx_if.master bus
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT     = CLKS_PER_BIT / 2;
`else
    localparam int START_PT     = CLKS_PER_BIT / 2 - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(START_PT);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_COMMIT
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic                 stop_idx;
    logic                 armed;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_acc;
    logic                 err_p;
    logic                 err_f;
    logic                 rx_p0;
    logic                 rx_p1;
    logic                 bit_val;
    logic                 bit_tick;

    logic [DATA_BITS-1:0] rx_data_r;
    logic                 rx_valid_r;
    logic                 perr_r;
    logic                 ferr_r;
    logic                 ovr_r;

    // Stage p0/p1: metastability synchroniser; idles high so reset never looks like a start.
`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_p2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0   <= 1'b1;
            rx_p1   <= 1'b1;
            vote_p2 <= 2'b11;
        end else begin
            rx_p0   <= rx;
            rx_p1   <= rx_p0;
            vote_p2 <= {vote_p2[0], rx_p1};
        end
    end

    // Decision point is mid+1: vote_p2 holds the mid-1 and mid samples.
    assign bit_val = majority3(vote_p2[1], vote_p2[0], rx_p1);
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
        end
    end

    assign bit_val = rx_p1;
`endif

    assign bit_tick = (cnt == CNT_LAST);

    // Frame FSM: sampling, error accumulation and commit into the held output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            idx        <= '0;
            stop_idx   <= 1'b0;
            armed      <= 1'b0;
            shreg      <= '0;
            par_acc    <= 1'b0;
            err_p      <= 1'b0;
            err_f      <= 1'b0;
            rx_data_r  <= '0;
            rx_valid_r <= 1'b0;
            perr_r     <= 1'b0;
            ferr_r     <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            ovr_r <= 1'b0;
            if (rx_valid_r && bus.rx_ready) begin
                rx_valid_r <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // Arming needs a high line first, so a stuck-low line cannot retrigger.
                    if (armed && !rx_p1) begin
                        state    <= S_START;
                        armed    <= 1'b0;
                        idx      <= '0;
                        stop_idx <= 1'b0;
                        par_acc  <= 1'b0;
                        err_p    <= 1'b0;
                        err_f    <= 1'b0;
                    end else if (rx_p1) begin
                        armed <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt == CNT_START) begin
                        cnt   <= '0;
                        state <= bit_val ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (bit_tick) begin
                        cnt     <= '0;
                        shreg   <= {bit_val, shreg[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ bit_val;
                        idx     <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        err_p <= ((par_acc ^ bit_val) != PAR_ODD);
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (!bit_val) begin
                            err_f <= 1'b1;
                        end
                        if (STOP_BITS == 1 || stop_idx) begin
                            state <= S_COMMIT;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                S_COMMIT: begin
                    state <= S_IDLE;
                    // A simultaneous accept frees the slot, so the new frame may replace the old.
                    if (!rx_valid_r || bus.rx_ready) begin
                        rx_data_r  <= shreg;
                        perr_r     <= err_p;
                        ferr_r     <= err_f;
                        rx_valid_r <= 1'b1;
                    end else begin
                        ovr_r <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.rx_data    = rx_data_r;
    assign bus.rx_valid   = rx_valid_r;
    assign bus.parity_err = perr_r;
    assign bus.frame_err  = ferr_r;
    assign bus.overrun    = ovr_r;
    assign busy           = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three configurations (8N1, 7E1, 9N2) at 16 clocks per bit.
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst_n;
    logic rx_a, rx_b, rx_c;
    logic busy_a, busy_b, busy_c;

    int n_asrt = 0;
    int n_fail = 0;
    int ovr_a  = 0;
    int ovr_mark;
    int spike_bit;

    logic [10:0] q_a[$];
    logic [10:0] q_b[$];
    logic [10:0] q_c[$];
    logic [10:0] e;

    always #5 clk = ~clk;

    uart_rx_if #(.DATA_BITS(8)) bus_a ();
    uart_rx_if #(.DATA_BITS(7)) bus_b ();
    uart_rx_if #(.DATA_BITS(9)) bus_c ();

    uart_rx_cfg #(
        .CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .busy(busy_a), .bus(bus_a.master)
    );

    uart_rx_cfg #(
        .CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .busy(busy_b), .bus(bus_b.master)
    );

    uart_rx_cfg #(
        .CLK_FREQ(1000000), .BAUD_RATE(62500), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)
    ) dut_c (
        .clk(clk), .rst_n(rst_n), .rx(rx_c), .busy(busy_c), .bus(bus_c.master)
    );

    // Accepted frames packed as {parity_err, frame_err, data}.
    always @(negedge clk) begin
        if (bus_a.rx_valid && bus_a.rx_ready)
            q_a.push_back({bus_a.parity_err, bus_a.frame_err, 9'(bus_a.rx_data)});
        if (bus_b.rx_valid && bus_b.rx_ready)
            q_b.push_back({bus_b.parity_err, bus_b.frame_err, 9'(bus_b.rx_data)});
        if (bus_c.rx_valid && bus_c.rx_ready)
            q_c.push_back({bus_c.parity_err, bus_c.frame_err, 9'(bus_c.rx_data)});
        if (bus_a.overrun)
            ovr_a++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v);
        case (sel)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic send_bits(input int sel, input logic [15:0] bits, input int n, input int spike_at);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i]);
            if (i == spike_at) begin
                tick(8);
                drive(sel, !bits[i]);
                tick(1);
                drive(sel, bits[i]);
                tick(7);
            end else begin
                tick(16);
            end
        end
    endtask

    task automatic pop(input int sel, output logic [10:0] v);
        v = 11'h7FF;
        case (sel)
            0:       if (q_a.size() > 0) v = q_a.pop_front();
            1:       if (q_b.size() > 0) v = q_b.pop_front();
            default: if (q_c.size() > 0) v = q_c.pop_front();
        endcase
    endtask

    initial begin
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        bus_a.rx_ready = 1'b1;
        bus_b.rx_ready = 1'b1;
        bus_c.rx_ready = 1'b1;
        rst_n = 1'b0;
        tick(3);

        chk("rst_valid",  32'(bus_a.rx_valid),   32'd0);
        chk("rst_data",   32'(bus_a.rx_data),    32'd0);
        chk("rst_perr",   32'(bus_a.parity_err), 32'd0);
        chk("rst_ferr",   32'(bus_a.frame_err),  32'd0);
        chk("rst_ovr",    32'(bus_a.overrun),    32'd0);
        chk("rst_busy",   32'({busy_a, busy_b, busy_c}), 32'd0);

        rst_n = 1'b1;
        tick(40);

        // 8N1 back-to-back
        send_bits(0, 16'({1'b1, 8'hA5, 1'b0}), 10, -1);
        send_bits(0, 16'({1'b1, 8'h3C, 1'b0}), 10, -1);
        tick(48);
        chk("s1_count", 32'(q_a.size()), 32'd2);
        pop(0, e); chk("s1_frame_a5", 32'(e), 32'h0A5);
        pop(0, e); chk("s1_frame_3c", 32'(e), 32'h03C);
        chk("s1_overrun", 32'(ovr_a), 32'd0);

        // 7E1: correct then wrong parity bit
        send_bits(1, 16'({1'b1, 1'b0, 7'h55, 1'b0}), 10, -1);
        send_bits(1, 16'({1'b1, 1'b1, 7'h55, 1'b0}), 10, -1);
        tick(48);
        chk("s2_count", 32'(q_b.size()), 32'd2);
        pop(1, e); chk("s2_par_ok",  32'(e), 32'h055);
        pop(1, e); chk("s2_par_bad", 32'(e), 32'h455);

        // Overrun with consumer stalled
        bus_a.rx_ready = 1'b0;
        ovr_mark = ovr_a;
        send_bits(0, 16'({1'b1, 8'h11, 1'b0}), 10, -1);
        send_bits(0, 16'({1'b1, 8'h22, 1'b0}), 10, -1);
        tick(48);
        chk("s3_valid_held", 32'(bus_a.rx_valid), 32'd1);
        chk("s3_data_held",  32'(bus_a.rx_data),  32'h11);
        chk("s3_ovr_pulses", 32'(ovr_a - ovr_mark), 32'd1);
        chk("s3_no_accept",  32'(q_a.size()), 32'd0);
        bus_a.rx_ready = 1'b1;
        tick(1);
        chk("s3_valid_drop", 32'(bus_a.rx_valid), 32'd0);
        chk("s3_data_kept",  32'(bus_a.rx_data),  32'h11);
        pop(0, e); chk("s3_accepted", 32'(e), 32'h011);

        // Stop bit low followed by a long break
        send_bits(0, 16'({1'b0, 8'h0F, 1'b0}), 10, -1);
        tick(20 * 16);
        chk("s4_break_idle", 32'(busy_a), 32'd0);
        tick(20 * 16);
        drive(0, 1'b1);
        tick(48);
        pop(0, e); chk("s4_frame_err", 32'(e), 32'h20F);
        chk("s4_single_frame", 32'(q_a.size()), 32'd0);

        // 5-cycle glitch is a false start
        drive(0, 1'b0);
        tick(4);
        chk("s4_glitch_busy", 32'(busy_a), 32'd1);
        tick(1);
        drive(0, 1'b1);
        tick(48);
        chk("s4_glitch_idle", 32'(busy_a), 32'd0);
        chk("s4_glitch_nofr", 32'(q_a.size()), 32'd0);

        // 9-bit, two stop bits; then second stop bit low
        send_bits(2, 16'({2'b11, 9'h1FF, 1'b0}), 12, -1);
        send_bits(2, 16'({1'b0, 1'b1, 9'h1FF, 1'b0}), 12, -1);
        drive(2, 1'b1);
        tick(48);
        chk("s5_count", 32'(q_c.size()), 32'd2);
        pop(2, e); chk("s5_frame_ok",  32'(e), 32'h1FF);
        pop(2, e); chk("s5_stop2_low", 32'(e), 32'h3FF);

        // Reset during data bit 3 of 0x81, then a clean resend
        send_bits(0, 16'b0010, 4, -1);
        drive(0, 1'b0);
        tick(8);
        chk("s6_busy_mid", 32'(busy_a), 32'd1);
        rst_n = 1'b0;
        tick(2);
        chk("s6_rst_valid", 32'(bus_a.rx_valid), 32'd0);
        chk("s6_rst_data",  32'(bus_a.rx_data),  32'd0);
        chk("s6_rst_ferr",  32'(bus_a.frame_err), 32'd0);
        chk("s6_rst_busy",  32'(busy_a), 32'd0);
        rst_n = 1'b1;
        drive(0, 1'b1);
        tick(48);
`ifdef UART_RX_MAJORITY_EN
        spike_bit = 3;
`else
        spike_bit = -1;
`endif
        send_bits(0, 16'({1'b1, 8'h81, 1'b0}), 10, spike_bit);
        tick(48);
        chk("s6_count", 32'(q_a.size()), 32'd1);
        pop(0, e); chk("s6_frame_81", 32'(e), 32'h081);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the team's fixed 8N1 UART receiver.
- Configurable data width, parity mode and stop-bit count.
- Mid-bit sampling with false-start rejection.
- Parity and framing error reporting.
- Held valid/ready output with overrun detection.
- Sits between the pad-level rx line and the host-side byte consumer (FIFO or register interface).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE, integer division, must be >= 8.
- DATA_BITS, 8, data bits per frame. Legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame. Legal values 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- rx  in  1  asynchronous serial input, idle high.
- rx_data  out  DATA_BITS  received word, LSB = first bit on the line.
- rx_valid  out  1  rx_data and error flags hold a frame; stays high until accepted.
- rx_ready  in  1  consumer accepts the frame on a cycle where rx_valid && rx_ready.
- parity_err  out  1  parity mismatch for the held frame. Always 0 when PARITY = 0.
- frame_err  out  1  a stop bit sampled low for the held frame.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State IDLE; all counters 0; armed = 0.
  - Sync flops = 1.
  - rx_data = 0; rx_valid, parity_err, frame_err, overrun and busy = 0.
  - Reset mid-frame abandons the frame; no partial output.
- Input conditioning:
  - rx passes through a 2-flop synchroniser reset to 1; rxs denotes the synchronised value.
  - All timing is relative to rxs, i.e. 2 cycles behind the pin.
- Arming:
  - armed sets when rxs = 1 in IDLE.
  - A start is detected only when armed && rxs = 0, which prevents break/low-line retriggering after a frame error.
  - armed clears on leaving IDLE.
- States and transitions:
  - IDLE: on start detect, go START with bit counter = 0.
  - START: wait until bit counter = CLKS_PER_BIT/2 - 1 (mid start bit).
    - rxs = 1 there: false start, return to IDLE; no output, no flags.
    - rxs = 0 there: go DATA with counter cleared and bit index = 0.
  - DATA: sample every CLKS_PER_BIT cycles, at mid-bit.
    - Store at bit_index, LSB first; running parity XOR updated.
    - After DATA_BITS samples, go PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. err_p = (XOR of data ^ sample) != (PARITY == 1 ? 1 : 0); odd requires total ones odd.
  - STOP: STOP_BITS samples; err_f is set if any sample = 0.
    - On the last stop sample (mid-bit), go to the commit step, then IDLE.
    - The receiver is back in IDLE half a bit early, so back-to-back frames are accepted.
- Commit (the cycle after the last stop sample):
  - rx_valid = 0, or rx_ready = 1 in the same cycle: load rx_data, parity_err = err_p, frame_err = err_f; rx_valid = 1.
  - Otherwise: new frame discarded, old frame kept intact, overrun = 1 for exactly one cycle.
- Handshake:
  - rx_valid clears on the cycle after acceptance unless a commit occurs in that same cycle, which takes priority and reloads.
  - rx_data and flags are stable while rx_valid && !rx_ready.
- Widths: bit counter is clog2(CLKS_PER_BIT) bits wide and wraps to 0 at CLKS_PER_BIT - 1; bit index is clog2(DATA_BITS+1) bits wide.
- Latency: rx_valid rises (CLKS_PER_BIT/2 + (1 + DATA_BITS + P + STOP_BITS - 1)·CLKS_PER_BIT) + 4 cycles after the rx falling edge at the pin, ±1 cycle. P = 1 if parity is enabled, else 0. The +4 covers sync, detect and commit.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined:
  - Every bit (start, data, parity, stop) is sampled at mid-1, mid and mid+1 cycles.
  - The bit value is the majority of the three samples.
  - The decision and state advance happen at mid+1, so all downstream timing shifts +1 cycle.
  - False-start check uses the majority value.
- Undefined: single sample at mid only; no vote logic is present.

Test Plan:
Common setup for scenarios 1–4: CLK_FREQ = 1000000, BAUD_RATE = 62500, so CLKS_PER_BIT = 16.
1. 8N1: send 0xA5 then 0x3C back-to-back with rx_ready = 1 → rx_valid pulses twice; rx_data = 0xA5 then 0x3C; parity_err = frame_err = overrun = 0.
2. PARITY = 2, DATA_BITS = 7: send 0x55 with parity bit 0 → rx_data = 0x55, parity_err = 0. Send 0x55 with parity bit 1 → parity_err = 1.
3. rx_ready = 0: send 0x11 then 0x22 → rx_valid held; rx_data stays 0x11; overrun pulses 1 cycle at the second commit. Then assert rx_ready → rx_valid drops; rx_data is still 0x11.
4. Framing and false start:
   - Send 0x0F with stop bit low, then hold rx low for 40 bits → one frame with frame_err = 1; no further frames until rx returns high.
   - Then a 5-cycle low glitch → no rx_valid; busy returns 0.
5. STOP_BITS = 2, DATA_BITS = 9: send 0x1FF → rx_data = 0x1FF. Second stop bit low → frame_err = 1.
6. Reset mid-frame: assert rst_n low during data bit 3 of 0x81, then resend 0x81 → all outputs 0 during reset; the next frame is received cleanly as 0x81. With UART_RX_MAJORITY_EN, a 1-cycle inverted spike at mid of bit 2 must not corrupt the data.
